mcdt_arbiter: RTL and testbench
===============================

MCDT_ARBITER -- requirements
Module: mcdt_arbiter

Interface
REQ-001 SHALL provide parameter DW, default 32, channel data width.
REQ-002 SHALL provide parameter BURST_LEN, default 4, maximum consecutive grants to one channel (legal 1..15).
REQ-003 SHALL provide port clk_i  input  1  single clock, all logic on rising edge.
REQ-004 SHALL provide port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL provide ports ch0_req_i/ch1_req_i/ch2_req_i  input  1 each  channel FIFO non-empty.
REQ-006 SHALL provide ports ch0_data_i/ch1_data_i/ch2_data_i  input  DW each  channel FIFO head word (first-word-fall-through).
REQ-007 SHALL provide ports ch0_gnt_o/ch1_gnt_o/ch2_gnt_o  output  1 each  pop strobe to channel FIFO.
REQ-008 SHALL provide port mode_i  input  1  0 = round-robin, 1 = fixed priority.
REQ-009 SHALL provide port prio_i  input  6  2-bit priority per channel, bits[1:0] = ch0; lower value wins.
REQ-010 SHALL provide port mcdt_data_o  output  DW  formatted output word.
REQ-011 SHALL provide port mcdt_val_o  output  1  mcdt_data_o/mcdt_id_o valid this cycle.
REQ-012 SHALL provide port mcdt_id_o  output  2  source channel of mcdt_data_o (0..2).

Function
REQ-013 SHALL compute grant combinationally from requests and registered state; at most one chX_gnt_o high per cycle, and never without its chX_req_i.
REQ-014 SHALL register granted word: grant in cycle n -> mcdt_val_o=1, mcdt_data_o=word, mcdt_id_o=channel in cycle n+1 (latency 1, one word per cycle sustained).
REQ-015 SHALL drive mcdt_val_o=0, mcdt_data_o=0 and mcdt_id_o=0 in any cycle following a no-grant cycle.
REQ-016 SHALL implement FSM IDLE/BURST with registered cur_id (2b) and burst count cnt (4b).
REQ-017 IDLE: no request -> stay IDLE; any request -> grant winner, go BURST, cur_id=winner, cnt=1.
REQ-018 BURST: req of cur_id high and cnt<BURST_LEN -> grant cur_id again, cnt+1.
REQ-019 BURST: req of cur_id low or cnt==BURST_LEN -> pick new winner (same cycle, no bubble), cnt=1; none requesting -> no grant, go IDLE.
REQ-020 Round-robin winner SHALL be first requester scanning cur_id+1, cur_id+2, cur_id (mod 3); cur_id itself only if it is sole requester, in which case its burst restarts with cnt=1.
REQ-021 Fixed-priority winner SHALL be requester with lowest prio field; ties resolved to lowest channel id; burst limit still applies.
REQ-022 mode_i and prio_i changes SHALL take effect only at the next winner selection, not mid-burst.
REQ-023 BURST_LEN=1 SHALL yield strict word-by-word alternation among active requesters.

Reset
REQ-024 rst_i high SHALL immediately force state IDLE, cur_id=2 (ch0 wins first round-robin), cnt=0, all chX_gnt_o=0, mcdt_val_o=0, mcdt_data_o=0, mcdt_id_o=0.
REQ-025 Reset asserted mid-burst SHALL discard the in-flight output word; first grant SHALL occur in the first clock edge after rst_i deasserts with a request present.

Configuration
REQ-026 With MCDT_ARB_STATS_EN defined, SHALL add inputs stat_clr_i (1b) and outputs ch0_cnt_o/ch1_cnt_o/ch2_cnt_o (16b each): per-channel grant counters, +1 per grant, saturating at 16'hFFFF, cleared synchronously by stat_clr_i (clear wins over same-cycle increment), reset to 0.
REQ-027 Without MCDT_ARB_STATS_EN, those ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-028 Only ch0 requests, 10 words 'h00C0_0000..9, mode_i=0, BURST_LEN=4 -> 10 contiguous mcdt_val_o pulses, id=0, data in order, first 1 cycle after first gnt.
REQ-029 All three requesting continuously, mode_i=0, BURST_LEN=4 -> ids 0,0,0,0,1,1,1,1,2,2,2,2,0..., no idle cycle.
REQ-030 All requesting, mode_i=1, prio_i=6'b00_01_10 -> ch2 bursts of 4 while its FIFO is non-empty; ch1 served only once ch2 req drops; ch0 last.
REQ-031 ch1 requesting alone, ch0 raises req at ch1 burst word 2 -> ch1 completes 4 words, then ch0 granted next cycle without bubble.
REQ-032 rst_i pulsed for 1 cycle during ch2 burst word 3 -> all outputs 0 immediately, next grant goes to ch0 when all request.
REQ-033 MCDT_ARB_STATS_EN defined, 5 ch1 grants then stat_clr_i with concurrent grant -> ch1_cnt_o reads 5, then 0.

Source files
------------

// File: rtl/mcdt_arbiter.sv
// Three-channel arbiter: round-robin or fixed-priority bursts into one registered output stream.
// Define MCDT_ARB_STATS_EN to add per-channel saturating grant counters (stat_clr_i, chX_cnt_o).
module mcdt_arbiter #(
    parameter int DW        = 32,
    parameter int BURST_LEN = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
`ifdef MCDT_ARB_STATS_EN
    input  logic          stat_clr_i,
    output logic [15:0]   ch0_cnt_o,
    output logic [15:0]   ch1_cnt_o,
    output logic [15:0]   ch2_cnt_o,
`endif
    input  logic          ch0_req_i,
    input  logic          ch1_req_i,
    input  logic          ch2_req_i,
    input  logic [DW-1:0] ch0_data_i,
    input  logic [DW-1:0] ch1_data_i,
    input  logic [DW-1:0] ch2_data_i,
    output logic          ch0_gnt_o,
    output logic          ch1_gnt_o,
    output logic          ch2_gnt_o,
    input  logic          mode_i,
    input  logic [5:0]    prio_i,
    output logic [DW-1:0] mcdt_data_o,
    output logic          mcdt_val_o,
    output logic [1:0]    mcdt_id_o
);

    typedef enum logic {IDLE, BURST} state_t;

    localparam logic [3:0] BL = 4'(BURST_LEN);

    state_t        state, state_n;
    logic [1:0]    cur_id, cur_id_n;
    logic [3:0]    cnt, cnt_n;

    logic [3:0]    req;
    logic [1:0]    rr_a, rr_b, rr_id;
    logic [1:0]    fp_id, fp_p;
    logic          fp_found;
    logic          keep, any;
    logic [1:0]    gnt_id;
    logic [2:0]    gnt;
    logic [DW-1:0] sel_data;

    function automatic logic [1:0] next_id(input logic [1:0] id);
        return (id == 2'd2) ? 2'd0 : id + 2'd1;
    endfunction

    assign req = {1'b0, ch2_req_i, ch1_req_i, ch0_req_i};

    // Winner candidates; only consulted when a new selection is due
    always_comb begin
        rr_a     = next_id(cur_id);
        rr_b     = next_id(rr_a);
        rr_id    = cur_id;
        if (req[rr_a])
            rr_id = rr_a;
        else if (req[rr_b])
            rr_id = rr_b;

        fp_id    = 2'd0;
        fp_p     = 2'b11;
        fp_found = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (req[i] && (!fp_found || prio_i[2*i +: 2] < fp_p)) begin
                fp_found = 1'b1;
                fp_p     = prio_i[2*i +: 2];
                fp_id    = 2'(i);
            end
        end
    end

    always_comb begin
        keep     = (state == BURST) && req[cur_id] && (cnt < BL);
        any      = (|req) && !rst_i;
        gnt_id   = keep ? cur_id : (mode_i ? fp_id : rr_id);
        gnt      = any ? (3'b001 << gnt_id) : '0;

        state_n  = state;
        cur_id_n = cur_id;
        cnt_n    = cnt;
        if (any) begin
            state_n  = BURST;
            cur_id_n = gnt_id;
            cnt_n    = keep ? cnt + 4'd1 : 4'd1;
        end else begin
            state_n  = IDLE;
            cnt_n    = '0;
        end
    end

    assign ch0_gnt_o = gnt[0];
    assign ch1_gnt_o = gnt[1];
    assign ch2_gnt_o = gnt[2];

    always_comb begin
        case (gnt_id)
            2'd0:    sel_data = ch0_data_i;
            2'd1:    sel_data = ch1_data_i;
            default: sel_data = ch2_data_i;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            cur_id <= 2'd2;
            cnt    <= '0;
        end else begin
            state  <= state_n;
            cur_id <= cur_id_n;
            cnt    <= cnt_n;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcdt_val_o  <= 1'b0;
            mcdt_data_o <= '0;
            mcdt_id_o   <= '0;
        end else begin
            mcdt_val_o  <= any;
            mcdt_data_o <= any ? sel_data : '0;
            mcdt_id_o   <= any ? gnt_id : '0;
        end
    end

`ifdef MCDT_ARB_STATS_EN
    logic [15:0] stat_cnt [3];

    // Clear has priority over a same-cycle grant
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < 3; i++) stat_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (stat_clr_i)
                    stat_cnt[i] <= '0;
                else if (gnt[i] && stat_cnt[i] != '1)
                    stat_cnt[i] <= stat_cnt[i] + 16'd1;
            end
        end
    end

    assign ch0_cnt_o = stat_cnt[0];
    assign ch1_cnt_o = stat_cnt[1];
    assign ch2_cnt_o = stat_cnt[2];
`endif

endmodule

// File: tb/tb_mcdt_arbiter.sv
// Scoreboard bench for mcdt_arbiter: FIFO models feed the channels, expected words are queued per test.
module tb_mcdt_arbiter;

    localparam int DW = 32;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          ch0_req, ch1_req, ch2_req;
    logic [DW-1:0] ch0_data, ch1_data, ch2_data;
    logic          ch0_gnt, ch1_gnt, ch2_gnt;
    logic          mode;
    logic [5:0]    prio;
    logic [DW-1:0] mcdt_data;
    logic          mcdt_val;
    logic [1:0]    mcdt_id;

    // Second instance with BURST_LEN=1 and constant channel data
    logic [2:0]    b1_req;
    logic          b1_gnt0, b1_gnt1, b1_gnt2;
    logic [DW-1:0] b1_data;
    logic          b1_val;
    logic [1:0]    b1_id;

`ifdef MCDT_ARB_STATS_EN
    logic        stat_clr;
    logic [15:0] ch0_cnt, ch1_cnt, ch2_cnt;
    logic [15:0] b1_cnt0, b1_cnt1, b1_cnt2;
`endif

    mcdt_arbiter #(.DW(DW), .BURST_LEN(4)) u_dut (
        .clk_i(clk), .rst_i(rst),
`ifdef MCDT_ARB_STATS_EN
        .stat_clr_i(stat_clr), .ch0_cnt_o(ch0_cnt), .ch1_cnt_o(ch1_cnt), .ch2_cnt_o(ch2_cnt),
`endif
        .ch0_req_i(ch0_req), .ch1_req_i(ch1_req), .ch2_req_i(ch2_req),
        .ch0_data_i(ch0_data), .ch1_data_i(ch1_data), .ch2_data_i(ch2_data),
        .ch0_gnt_o(ch0_gnt), .ch1_gnt_o(ch1_gnt), .ch2_gnt_o(ch2_gnt),
        .mode_i(mode), .prio_i(prio),
        .mcdt_data_o(mcdt_data), .mcdt_val_o(mcdt_val), .mcdt_id_o(mcdt_id)
    );

    mcdt_arbiter #(.DW(DW), .BURST_LEN(1)) u_dut_b1 (
        .clk_i(clk), .rst_i(rst),
`ifdef MCDT_ARB_STATS_EN
        .stat_clr_i(1'b0), .ch0_cnt_o(b1_cnt0), .ch1_cnt_o(b1_cnt1), .ch2_cnt_o(b1_cnt2),
`endif
        .ch0_req_i(b1_req[0]), .ch1_req_i(b1_req[1]), .ch2_req_i(b1_req[2]),
        .ch0_data_i(32'hB100_0000), .ch1_data_i(32'hB100_0001), .ch2_data_i(32'hB100_0002),
        .ch0_gnt_o(b1_gnt0), .ch1_gnt_o(b1_gnt1), .ch2_gnt_o(b1_gnt2),
        .mode_i(1'b0), .prio_i(6'b0),
        .mcdt_data_o(b1_data), .mcdt_val_o(b1_val), .mcdt_id_o(b1_id)
    );

    logic [31:0] fq0[$], fq1[$], fq2[$];
    exp_t        exp_q[$];
    logic [1:0]  exp1_q[$];
    int unsigned nxt_ld[3];
    int unsigned nxt_ex[3];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic [31:0] word(input int unsigned ch, input int unsigned idx);
        return 32'h00C0_0000 + 32'(ch * 4096) + 32'(idx);
    endfunction

    task automatic refresh();
        ch0_req  = (fq0.size() != 0);
        ch1_req  = (fq1.size() != 0);
        ch2_req  = (fq2.size() != 0);
        ch0_data = (fq0.size() != 0) ? fq0[0] : '0;
        ch1_data = (fq1.size() != 0) ? fq1[0] : '0;
        ch2_data = (fq2.size() != 0) ? fq2[0] : '0;
    endtask

    task automatic load(input int unsigned ch, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            case (ch)
                0:       fq0.push_back(word(ch, nxt_ld[ch]));
                1:       fq1.push_back(word(ch, nxt_ld[ch]));
                default: fq2.push_back(word(ch, nxt_ld[ch]));
            endcase
            nxt_ld[ch]++;
        end
        refresh();
    endtask

    task automatic expect_ch(input int unsigned ch, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            exp_q.push_back({2'(ch), word(ch, nxt_ex[ch])});
            nxt_ex[ch]++;
        end
    endtask

    task automatic flush();
        fq0.delete(); fq1.delete(); fq2.delete();
        exp_q.delete(); exp1_q.delete();
        for (int unsigned i = 0; i < 3; i++) nxt_ex[i] = nxt_ld[i];
        refresh();
    endtask

    // One clock: grant checked at negedge, FIFOs popped and outputs checked #1 after posedge
    task automatic step();
        logic [2:0] g, g1;
        bit         have, have1;
        exp_t       e;
        logic [1:0] e1;
        @(negedge clk);
        g     = {ch2_gnt, ch1_gnt, ch0_gnt};
        g1    = {b1_gnt2, b1_gnt1, b1_gnt0};
        have  = (exp_q.size() != 0);
        have1 = (exp1_q.size() != 0);
        if (have) chk("gnt", 64'(g), 64'(3'b001 << exp_q[0].id));
        else      chk("gnt_idle", 64'(g), 64'd0);
        if (have1) chk("b1_gnt", 64'(g1), 64'(3'b001 << exp1_q[0]));
        else       chk("b1_gnt_idle", 64'(g1), 64'd0);
        @(posedge clk);
        #1;
        if (g[0] && fq0.size() != 0) void'(fq0.pop_front());
        if (g[1] && fq1.size() != 0) void'(fq1.pop_front());
        if (g[2] && fq2.size() != 0) void'(fq2.pop_front());
        refresh();
        if (have) begin
            e = exp_q.pop_front();
            chk("val", 64'(mcdt_val), 64'd1);
            chk("id", 64'(mcdt_id), 64'(e.id));
            chk("data", 64'(mcdt_data), 64'(e.data));
        end else begin
            chk("idle_val", 64'(mcdt_val), 64'd0);
            chk("idle_data", 64'(mcdt_data), 64'd0);
            chk("idle_id", 64'(mcdt_id), 64'd0);
        end
        if (have1) begin
            e1 = exp1_q.pop_front();
            chk("b1_val", 64'(b1_val), 64'd1);
            chk("b1_id", 64'(b1_id), 64'(e1));
            chk("b1_data", 64'(b1_data), 64'(32'hB100_0000 + 32'(e1)));
        end else begin
            chk("b1_idle_val", 64'(b1_val), 64'd0);
        end
    endtask

    task automatic run(input int unsigned budget);
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("timeout", 64'(exp_q.size()), 64'd0);
            flush();
        end
        step();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_val"}, 64'(mcdt_val), 64'd0);
        chk({tag, "_data"}, 64'(mcdt_data), 64'd0);
        chk({tag, "_id"}, 64'(mcdt_id), 64'd0);
        chk({tag, "_gnt"}, 64'({ch2_gnt, ch1_gnt, ch0_gnt}), 64'd0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        flush();
        @(posedge clk);
        #1;
        check_zero("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst    = 1'b1;
        mode   = 1'b0;
        prio   = 6'b0;
        b1_req = 3'b000;
`ifdef MCDT_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        for (int unsigned i = 0; i < 3; i++) begin
            nxt_ld[i] = 0;
            nxt_ex[i] = 0;
        end
        refresh();

        // Grants held off while reset is high even with a request pending
        load(1, 1);
        @(posedge clk);
        #1;
        check_zero("rst_req");
        apply_reset();

        // ch0 alone: 10 contiguous words 00C0_0000..9
        load(0, 10);
        expect_ch(0, 10);
        run(40);

        // All channels, round-robin bursts of 4
        apply_reset();
        load(0, 12); load(1, 12); load(2, 12);
        for (int r = 0; r < 3; r++) begin
            expect_ch(0, 4); expect_ch(1, 4); expect_ch(2, 4);
        end
        run(80);

        // Fixed priority: ch2 best, then ch1, ch0 last
        mode = 1'b1;
        prio = 6'b00_01_10;
        apply_reset();
        load(0, 2); load(1, 3); load(2, 6);
        expect_ch(2, 6); expect_ch(1, 3); expect_ch(0, 2);
        run(40);

        // Fixed priority tie between ch1 and ch2 resolves to ch1
        prio = 6'b00_00_01;
        apply_reset();
        load(0, 2); load(1, 2); load(2, 2);
        expect_ch(1, 2); expect_ch(2, 2); expect_ch(0, 2);
        run(40);

        // Mode switch mid-burst only applies at the next selection
        mode = 1'b0;
        prio = 6'b11_00_11;
        apply_reset();
        load(0, 6); load(1, 6);
        expect_ch(0, 4); expect_ch(1, 6); expect_ch(0, 2);
        step(); step();
        mode = 1'b1;
        run(40);

        // ch0 arrives during ch1 burst: ch1 finishes 4, ch0 follows without a bubble
        mode = 1'b0;
        apply_reset();
        load(1, 6);
        expect_ch(1, 4); expect_ch(0, 3); expect_ch(1, 2);
        step(); step();
        load(0, 3);
        run(40);

        // Reset pulse during ch2 burst word 3
        apply_reset();
        load(2, 6);
        expect_ch(2, 6);
        step(); step(); step();
        rst = 1'b1;
        #1;
        check_zero("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        flush();
        load(0, 2); load(1, 2); load(2, 2);
        expect_ch(0, 2); expect_ch(1, 2); expect_ch(2, 2);
        run(40);

        // BURST_LEN=1 instance alternates word by word
        apply_reset();
        b1_req = 3'b111;
        for (int unsigned i = 0; i < 6; i++) exp1_q.push_back(2'(i % 3));
        repeat (6) step();
        b1_req = 3'b000;
        step();

`ifdef MCDT_ARB_STATS_EN
        apply_reset();
        chk("cnt_rst", 64'(ch1_cnt), 64'd0);
        load(1, 5);
        expect_ch(1, 5);
        run(40);
        chk("cnt_ch1_5", 64'(ch1_cnt), 64'd5);
        chk("cnt_ch0_0", 64'(ch0_cnt), 64'd0);
        load(1, 1);
        expect_ch(1, 1);
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        chk("cnt_clr", 64'(ch1_cnt), 64'd0);
        load(1, 1);
        expect_ch(1, 1);
        step();
        chk("cnt_after_clr", 64'(ch1_cnt), 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
